// File: rtl/stall_controller_pkg.sv
// Shared pipeline definitions: HI/LO tracker states, mult/div timing, forwarding selects.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package stall_controller_pkg;

    // Cycles the mult/div unit stays occupied after issue.
    localparam int MULDIV_CYCLES_DEF = 32;
    localparam int MULDIV_CNT_W      = 6;

    // HI/LO occupancy tracker states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // Operand forwarding select codes used by the forwarding mux in EX.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // True when an ID source operand is really read and names the EX destination.
    function automatic logic src_hit(input logic [4:0] ex_rd,
                                     input logic [4:0] src,
                                     input logic       uses);
        return uses & (ex_rd == src);
    endfunction

endpackage

// File: rtl/stall_controller_muldiv_tracker.sv
// HI/LO occupancy tracker: IDLE -> BUSY (CYCLES cycles) -> DONE (1 cycle) -> IDLE/BUSY.
// Latency: issue in cycle N gives done in cycle N+CYCLES+1.
// Backpressure: issue while BUSY is ignored; the hazard logic keeps HI/LO users in ID.
module muldiv_tracker
    import stall_controller_pkg::*;
#(
    parameter int CYCLES = MULDIV_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    output muldiv_state_e state,
    output logic          busy,
    output logic          done
);

    localparam logic [MULDIV_CNT_W-1:0] CNT_LOAD = MULDIV_CNT_W'(CYCLES - 1);

    muldiv_state_e           state_q, state_d;
    logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;

    // State and down-counter registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter; DONE may re-issue directly so back-to-back ops lose no cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (issue) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign state = state_q;
    assign busy  = (state_q == BUSY);
    assign done  = (state_q == DONE);

endmodule

// File: rtl/stall_controller.sv
// Pipeline hazard unit: load-use and HI/LO stalls, taken-branch flush, stall counter.
// Latency: control outputs are combinational from ID/EX fields; stall_count lags one cycle.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX; a taken branch overrides it.
module stall_controller
    import stall_controller_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_a,
    input  logic [4:0]  id_rt_a,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_hilo_use,
    input  logic [4:0]  ex_rd_a,
    input  logic        ex_MemRead,
    input  logic        ex_RegWrite,
    input  logic        ex_muldiv_issue,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [15:0] stall_count
);

    muldiv_state_e md_state;
    logic          load_use;
    logic          hilo_hazard;
    logic          stall;
    logic          count_stall;
    logic [15:0]   stall_count_q, stall_count_d;

    muldiv_tracker #(
        .CYCLES (MULDIV_CYCLES)
    ) u_muldiv_tracker (
        .clk   (clk),
        .rst   (rst),
        .issue (ex_muldiv_issue),
        .state (md_state),
        .busy  (muldiv_busy),
        .done  (muldiv_done)
    );

    // Hazard decode; r0 is hardwired so a load targeting it never blocks.
    always_comb begin
        load_use    = ex_MemRead & ex_RegWrite & (ex_rd_a != 5'd0) &
                      (src_hit(ex_rd_a, id_rs_a, id_uses_rs) |
                       src_hit(ex_rd_a, id_rt_a, id_uses_rt));
        hilo_hazard = id_hilo_use & ((md_state != IDLE) | ex_muldiv_issue);
        stall       = load_use | hilo_hazard;
        count_stall = stall & ~ex_branch_taken;
    end

    // Pipeline enables; the taken branch wins because the stalled instruction is wrong-path.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Saturating stall counter next value.
    always_comb begin
        stall_count_d = stall_count_q;
        if (count_stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_stall_controller.sv
// Self-checking bench for stall_controller: a timing model feeds a scoreboard queue.
// Latency: expectations are pushed when a cycle's stimulus is driven, popped at that negedge.
// Backpressure: n/a.
module tb_stall_controller;

    localparam int C = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs_a, id_rt_a, ex_rd_a;
    logic        id_uses_rs, id_uses_rt, id_hilo_use;
    logic        ex_MemRead, ex_RegWrite, ex_muldiv_issue, ex_branch_taken;
    logic        pc_write, ifid_write, idex_bubble, ifid_flush;
    logic        muldiv_busy, muldiv_done;
    logic [15:0] stall_count;

    typedef struct packed {
        logic        pc_write;
        logic        ifid_write;
        logic        idex_bubble;
        logic        ifid_flush;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          cyc       = 0;
    int          issue_cyc = -1;
    logic [15:0] m_cnt     = 16'd0;

    stall_controller #(.MULDIV_CYCLES(C)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs_a         (id_rs_a),
        .id_rt_a         (id_rt_a),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_hilo_use     (id_hilo_use),
        .ex_rd_a         (ex_rd_a),
        .ex_MemRead      (ex_MemRead),
        .ex_RegWrite     (ex_RegWrite),
        .ex_muldiv_issue (ex_muldiv_issue),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_bubble     (idex_bubble),
        .ifid_flush      (ifid_flush),
        .muldiv_busy     (muldiv_busy),
        .muldiv_done     (muldiv_done),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".pc_write"},    {15'd0, pc_write},    {15'd0, e.pc_write});
            check({t, ".ifid_write"},  {15'd0, ifid_write},  {15'd0, e.ifid_write});
            check({t, ".idex_bubble"}, {15'd0, idex_bubble}, {15'd0, e.idex_bubble});
            check({t, ".ifid_flush"},  {15'd0, ifid_flush},  {15'd0, e.ifid_flush});
            check({t, ".busy"},        {15'd0, muldiv_busy}, {15'd0, e.busy});
            check({t, ".done"},        {15'd0, muldiv_done}, {15'd0, e.done});
            check({t, ".stall_count"}, stall_count,          e.cnt);
        end
    end

    // Drive one cycle: inputs already set by caller; predict, push, advance, update model.
    task automatic run_cycle(input string tag);
        exp_t e;
        logic mb, md, lu, hz, st;
        mb = !rst && (issue_cyc >= 0) && (cyc >= issue_cyc + 1) && (cyc <= issue_cyc + C);
        md = !rst && (issue_cyc >= 0) && (cyc == issue_cyc + C + 1);
        lu = ex_MemRead && ex_RegWrite && (ex_rd_a != 5'd0) &&
             ((id_uses_rs && (ex_rd_a == id_rs_a)) || (id_uses_rt && (ex_rd_a == id_rt_a)));
        hz = id_hilo_use && (mb || md || ex_muldiv_issue);
        st = lu || hz;
        if (ex_branch_taken) begin
            e.pc_write = 1'b1; e.ifid_write = 1'b1; e.idex_bubble = 1'b1; e.ifid_flush = 1'b1;
        end else if (st) begin
            e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_bubble = 1'b1; e.ifid_flush = 1'b0;
        end else begin
            e.pc_write = 1'b1; e.ifid_write = 1'b1; e.idex_bubble = 1'b0; e.ifid_flush = 1'b0;
        end
        e.busy = mb;
        e.done = md;
        e.cnt  = rst ? 16'd0 : m_cnt;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        if (rst) begin
            issue_cyc = -1;
            m_cnt     = 16'd0;
        end else begin
            if (st && !ex_branch_taken && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
            if (ex_muldiv_issue && !mb) issue_cyc = cyc;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        id_rs_a = 5'd0; id_rt_a = 5'd0; ex_rd_a = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_hilo_use = 1'b0;
        ex_MemRead = 1'b0; ex_RegWrite = 1'b0;
        ex_muldiv_issue = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                            input logic [4:0] rt, input logic urt, input logic rw);
        ex_MemRead = 1'b1; ex_RegWrite = rw; ex_rd_a = rd;
        id_rs_a = rs; id_uses_rs = urs; id_rt_a = rt; id_uses_rt = urt;
    endtask

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        run_cycle("reset0");
        id_hilo_use = 1'b1; ex_muldiv_issue = 1'b1;
        run_cycle("reset_hilo");
        idle_inputs();
        rst = 1'b0;
        run_cycle("idle");

        // Load-use on rs, then on rt
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1); run_cycle("lu_rs");
        idle_inputs();                                run_cycle("after_lu_rs");
        set_load(5'd9, 5'd3, 1'b1, 5'd9, 1'b1, 1'b1); run_cycle("lu_rt");
        // Non-hazards
        set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1); run_cycle("lu_r0");
        set_load(5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1); run_cycle("lu_nouse");
        set_load(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0); run_cycle("lu_norw");
        set_load(5'd7, 5'd6, 1'b1, 5'd8, 1'b1, 1'b1); run_cycle("lu_nomatch");
        set_load(5'd7, 5'd6, 1'b1, 5'd7, 1'b0, 1'b1); run_cycle("lu_rt_nouse");
        // Branch override
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1); ex_branch_taken = 1'b1; run_cycle("lu_branch");
        idle_inputs(); ex_branch_taken = 1'b1;        run_cycle("branch");
        idle_inputs();                                run_cycle("post_branch");

        // mult/div issue with HI/LO user held in ID across the whole operation
        ex_muldiv_issue = 1'b1; id_hilo_use = 1'b1; run_cycle("md_issue");
        ex_muldiv_issue = 1'b0;
        for (int i = 0; i < C + 3; i++) begin
            ex_branch_taken = (i == 5);
            run_cycle("md_run");
        end
        idle_inputs();

        // Back-to-back: re-issue in the DONE cycle
        ex_muldiv_issue = 1'b1; run_cycle("md2_issue");
        ex_muldiv_issue = 1'b0;
        for (int i = 0; i < C; i++) run_cycle("md2_busy");
        ex_muldiv_issue = 1'b1; run_cycle("md2_done_reissue");
        ex_muldiv_issue = 1'b0;
        // Reset on the 20th busy cycle of the reissued op
        for (int i = 0; i < 19; i++) run_cycle("md3_busy");
        rst = 1'b1; run_cycle("md3_reset");
        rst = 1'b0;
        for (int i = 0; i < C + 8; i++) run_cycle("post_reset");

        // Randomised mix (no reset)
        for (int i = 0; i < 400; i++) begin
            id_rs_a = 5'($urandom_range(0, 3)); id_rt_a = 5'($urandom_range(0, 3));
            ex_rd_a = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
            ex_MemRead = 1'($urandom); ex_RegWrite = 1'($urandom);
            id_hilo_use = 1'($urandom);
            ex_muldiv_issue = ($urandom_range(0, 15) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            run_cycle("rand");
        end
        idle_inputs();
        for (int i = 0; i < C + 3; i++) run_cycle("drain");

        // Saturation
        rst = 1'b1; run_cycle("sat_reset");
        rst = 1'b0;
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 70000; i++) run_cycle("sat");
        idle_inputs(); run_cycle("sat_hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
